// File: rtl/reg_file_ba.sv
// General-purpose register file: one write port, two registered read ports (A, B),
// busy scoreboard for read-after-write hazards, write-through bypass and R0 base zeroing on port A.
module reg_file_ba #(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    input  logic             BAout,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic             q_valid,
    output logic             busy_a,
    output logic             busy_b,
    output logic             stall
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    // Indices at or above NREGS exist only when NREGS is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < NREGS_W);
    endfunction

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [WIDTH-1:0] q_a_q;
    logic [WIDTH-1:0] q_a_d;
    logic [WIDTH-1:0] q_b_q;
    logic [WIDTH-1:0] q_b_d;
    logic             q_valid_q;
    logic             q_valid_d;

    logic             a_in_s;
    logic             b_in_s;
    logic             wr_in_s;
    logic             iss_in_s;
    logic             a_zero_s;
    logic             a_byp_s;
    logic             b_byp_s;
    logic             busy_a_s;
    logic             busy_b_s;
    logic             stall_s;
    logic [WIDTH-1:0] rd_a_val_s;
    logic [WIDTH-1:0] rd_b_val_s;

    // Operand lookup for both read ports: zeroing, bypass, hazard detection.
    always_comb begin
        a_in_s   = in_range(rd_a_addr);
        b_in_s   = in_range(rd_b_addr);
        wr_in_s  = in_range(wr_addr);
        iss_in_s = in_range(issue_addr);
        a_zero_s = BAout && (rd_a_addr == {AW{1'b0}});
        a_byp_s  = wr_en && (wr_addr == rd_a_addr);
        b_byp_s  = wr_en && (wr_addr == rd_b_addr);

        if (a_zero_s || !a_in_s) begin
            rd_a_val_s = {WIDTH{1'b0}};
            busy_a_s   = 1'b0;
        end else if (a_byp_s) begin
            rd_a_val_s = wr_data;
            busy_a_s   = 1'b0;
        end else begin
            rd_a_val_s = regs_q[rd_a_addr];
            busy_a_s   = busy_q[rd_a_addr];
        end

        if (!b_in_s) begin
            rd_b_val_s = {WIDTH{1'b0}};
            busy_b_s   = 1'b0;
        end else if (b_byp_s) begin
            rd_b_val_s = wr_data;
            busy_b_s   = 1'b0;
        end else begin
            rd_b_val_s = regs_q[rd_b_addr];
            busy_b_s   = busy_q[rd_b_addr];
        end

        stall_s = rd_en && (busy_a_s || busy_b_s);
    end

    // Next-state for register array, scoreboard and read outputs.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        q_a_d     = q_a_q;
        q_b_d     = q_b_q;
        q_valid_d = 1'b0;

        if (sclr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = {WIDTH{1'b0}};
            end
            busy_d    = {NREGS{1'b0}};
            q_a_d     = {WIDTH{1'b0}};
            q_b_d     = {WIDTH{1'b0}};
            q_valid_d = 1'b0;
        end else begin
            if (wr_en && wr_in_s) begin
                regs_d[wr_addr] = wr_data;
                busy_d[wr_addr] = 1'b0;
            end else begin
                busy_d = busy_q;
            end

            // Issue is applied after the writeback clear so a new producer wins.
            if (issue_en && iss_in_s) begin
                busy_d[issue_addr] = 1'b1;
            end else begin
                q_valid_d = 1'b0;
            end

            if (rd_en && !stall_s) begin
                q_a_d     = rd_a_val_s;
                q_b_d     = rd_b_val_s;
                q_valid_d = 1'b1;
            end else begin
                q_a_d     = q_a_q;
                q_b_d     = q_b_q;
                q_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            busy_q    <= {NREGS{1'b0}};
            q_a_q     <= {WIDTH{1'b0}};
            q_b_q     <= {WIDTH{1'b0}};
            q_valid_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            q_a_q     <= q_a_d;
            q_b_q     <= q_b_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q_a     = q_a_q;
    assign q_b     = q_b_q;
    assign q_valid = q_valid_q;
    assign busy_a  = busy_a_s;
    assign busy_b  = busy_b_s;
    assign stall   = stall_s;

endmodule

// File: tb/tb_reg_file_ba.sv
// Directed self-checking bench for reg_file_ba (WIDTH=32, NREGS=16).
module tb_reg_file_ba;

    logic        clk = 1'b0;
    logic        clr;
    logic        sclr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic        rd_en;
    logic [3:0]  rd_a_addr;
    logic [3:0]  rd_b_addr;
    logic        BAout;
    logic [31:0] q_a;
    logic [31:0] q_b;
    logic        q_valid;
    logic        busy_a;
    logic        busy_b;
    logic        stall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_file_ba #(.WIDTH(32), .NREGS(16)) dut (
        .clk(clk), .clr(clr), .sclr(sclr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .BAout(BAout),
        .q_a(q_a), .q_b(q_b), .q_valid(q_valid),
        .busy_a(busy_a), .busy_b(busy_b), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sclr = 1'b0; wr_en = 1'b0; issue_en = 1'b0; rd_en = 1'b0; BAout = 1'b0;
        wr_addr = 4'd0; wr_data = 32'd0; issue_addr = 4'd0; rd_a_addr = 4'd0; rd_b_addr = 4'd0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        idle_inputs();
        tick();
        total_cnt++; if (q_a !== 32'd0 || q_b !== 32'd0 || q_valid !== 1'b0) $display("FAIL reset_outputs: got q_a=%h q_b=%h v=%b exp 0 0 0", q_a, q_b, q_valid); else pass_cnt++;
        clr = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h0000_0077;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_a_addr = 4'd1; rd_b_addr = 4'd1;
        #2 clr = 1'b0;
        #1;
        total_cnt++; if (q_a !== 32'd0 || q_valid !== 1'b0) $display("FAIL reset_midread_async: got q_a=%h v=%b exp 0 0", q_a, q_valid); else pass_cnt++;
        tick();
        total_cnt++; if (q_valid !== 1'b0 || q_a !== 32'd0) $display("FAIL reset_held: got q_a=%h v=%b exp 0 0", q_a, q_valid); else pass_cnt++;
        clr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_a_addr = 4'(i); rd_b_addr = 4'(i);
            #1;
            total_cnt++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_busy r%0d: got %b%b exp 00", i, busy_a, busy_b); else pass_cnt++;
            tick();
            total_cnt++; if (q_a !== 32'd0 || q_b !== 32'd0 || q_valid !== 1'b1) $display("FAIL reset_read r%0d: got q_a=%h q_b=%h v=%b exp 0 0 1", i, q_a, q_b, q_valid); else pass_cnt++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_addr = 4'd5; wr_data = 32'h1234_5678;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_a_addr = 4'd0; rd_b_addr = 4'd5; BAout = 1'b0;
        tick();
        total_cnt++; if (q_a !== 32'hDEAD_BEEF || q_b !== 32'h1234_5678 || q_valid !== 1'b1) $display("FAIL rd_a0_b5: got %h %h v=%b exp deadbeef 12345678 1", q_a, q_b, q_valid); else pass_cnt++;
        BAout = 1'b1;
        tick();
        total_cnt++; if (q_a !== 32'd0 || q_b !== 32'h1234_5678) $display("FAIL rd_baout_a0: got %h %h exp 0 12345678", q_a, q_b); else pass_cnt++;
        rd_a_addr = 4'd5; rd_b_addr = 4'd0;
        tick();
        total_cnt++; if (q_a !== 32'h1234_5678 || q_b !== 32'hDEAD_BEEF) $display("FAIL rd_baout_b0: got %h %h exp 12345678 deadbeef", q_a, q_b); else pass_cnt++;
        rd_en = 1'b0; BAout = 1'b0;
        tick();
        total_cnt++; if (q_valid !== 1'b0 || q_a !== 32'h1234_5678) $display("FAIL idle_hold: got q_a=%h v=%b exp 12345678 0", q_a, q_valid); else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5_A5A5;
        rd_en = 1'b1; rd_a_addr = 4'd3; rd_b_addr = 4'd3;
        tick();
        total_cnt++; if (q_a !== 32'hA5A5_A5A5 || q_b !== 32'hA5A5_A5A5) $display("FAIL bypass: got %h %h exp a5a5a5a5 x2", q_a, q_b); else pass_cnt++;
        wr_en = 1'b0;
        tick();
        total_cnt++; if (q_a !== 32'hA5A5_A5A5 || q_b !== 32'hA5A5_A5A5) $display("FAIL bypass_stored: got %h %h exp a5a5a5a5 x2", q_a, q_b); else pass_cnt++;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hCAFE_F00D;
        rd_a_addr = 4'd0; rd_b_addr = 4'd0; BAout = 1'b1;
        tick();
        total_cnt++; if (q_a !== 32'd0 || q_b !== 32'hCAFE_F00D) $display("FAIL bypass_baout: got %h %h exp 0 cafef00d", q_a, q_b); else pass_cnt++;
        wr_en = 1'b0; BAout = 1'b0; rd_b_addr = 4'd3;
        tick();
        total_cnt++; if (q_a !== 32'hCAFE_F00D || q_b !== 32'hA5A5_A5A5) $display("FAIL r0_writable: got %h %h exp cafef00d a5a5a5a5", q_a, q_b); else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        issue_en = 1'b1; issue_addr = 4'd7;
        tick();
        issue_en = 1'b0; rd_en = 1'b1; rd_a_addr = 4'd7; rd_b_addr = 4'd7;
        #1;
        total_cnt++; if (busy_a !== 1'b1 || busy_b !== 1'b1 || stall !== 1'b1) $display("FAIL hazard_detect: got %b%b%b exp 111", busy_a, busy_b, stall); else pass_cnt++;
        tick();
        total_cnt++; if (q_valid !== 1'b0 || q_a !== 32'hCAFE_F00D || q_b !== 32'hA5A5_A5A5) $display("FAIL hazard_hold: got %h %h v=%b exp cafef00d a5a5a5a5 0", q_a, q_b, q_valid); else pass_cnt++;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_0055;
        #1;
        total_cnt++; if (busy_a !== 1'b0 || stall !== 1'b0) $display("FAIL hazard_wb_unstall: got busy_a=%b stall=%b exp 0 0", busy_a, stall); else pass_cnt++;
        tick();
        total_cnt++; if (q_a !== 32'h55 || q_b !== 32'h55 || q_valid !== 1'b1) $display("FAIL hazard_wb_data: got %h %h v=%b exp 55 55 1", q_a, q_b, q_valid); else pass_cnt++;
        wr_en = 1'b0;
        #1;
        total_cnt++; if (busy_a !== 1'b0 || stall !== 1'b0) $display("FAIL busy_cleared: got busy_a=%b stall=%b exp 0 0", busy_a, stall); else pass_cnt++;
        rd_en = 1'b0; issue_en = 1'b1; issue_addr = 4'd0;
        tick();
        issue_en = 1'b0; rd_a_addr = 4'd0; rd_b_addr = 4'd0;
        #1;
        total_cnt++; if (busy_a !== 1'b1 || stall !== 1'b0) $display("FAIL stall_needs_rd_en: got busy_a=%b stall=%b exp 1 0", busy_a, stall); else pass_cnt++;
        rd_en = 1'b1; BAout = 1'b1;
        #1;
        total_cnt++; if (busy_a !== 1'b0 || busy_b !== 1'b1 || stall !== 1'b1) $display("FAIL baout_busy: got %b%b%b exp 011", busy_a, busy_b, stall); else pass_cnt++;
        rd_en = 1'b0; BAout = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd0;
        tick();
        wr_en = 1'b0; issue_en = 1'b1; issue_addr = 4'd6; rd_en = 1'b1; rd_a_addr = 4'd6; rd_b_addr = 4'd6;
        #1;
        total_cnt++; if (busy_a !== 1'b0 || stall !== 1'b0) $display("FAIL same_cycle_issue: got busy_a=%b stall=%b exp 0 0", busy_a, stall); else pass_cnt++;
        tick();
        total_cnt++; if (q_valid !== 1'b1 || q_a !== 32'd0) $display("FAIL same_cycle_issue_read: got q_a=%h v=%b exp 0 1", q_a, q_valid); else pass_cnt++;
        issue_en = 1'b0;
        #1;
        total_cnt++; if (busy_a !== 1'b1 || stall !== 1'b1) $display("FAIL issue_takes_effect: got busy_a=%b stall=%b exp 1 1", busy_a, stall); else pass_cnt++;
        rd_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'd0;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_set_wins();
        issue_en = 1'b1; issue_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h11;
        tick();
        issue_en = 1'b0; wr_en = 1'b0; rd_en = 1'b1; rd_a_addr = 4'd9; rd_b_addr = 4'd1;
        #1;
        total_cnt++; if (busy_a !== 1'b1 || stall !== 1'b1) $display("FAIL set_wins_busy: got busy_a=%b stall=%b exp 1 1", busy_a, stall); else pass_cnt++;
        tick();
        total_cnt++; if (q_valid !== 1'b0) $display("FAIL set_wins_stall: got v=%b exp 0", q_valid); else pass_cnt++;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
        tick();
        total_cnt++; if (q_a !== 32'h99 || q_valid !== 1'b1) $display("FAIL set_wins_release: got q_a=%h v=%b exp 99 1", q_a, q_valid); else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_soft_clear();
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'h100 + 32'(i);
            tick();
        end
        wr_en = 1'b0; issue_en = 1'b1; issue_addr = 4'd2;
        tick();
        issue_en = 1'b0; rd_en = 1'b1; rd_a_addr = 4'd1; rd_b_addr = 4'd3;
        tick();
        total_cnt++; if (q_a !== 32'h101 || q_b !== 32'h103) $display("FAIL sclr_preload: got %h %h exp 101 103", q_a, q_b); else pass_cnt++;
        sclr = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFF;
        issue_en = 1'b1; issue_addr = 4'd4; rd_b_addr = 4'd4;
        tick();
        total_cnt++; if (q_a !== 32'd0 || q_b !== 32'd0 || q_valid !== 1'b0) $display("FAIL sclr_outputs: got %h %h v=%b exp 0 0 0", q_a, q_b, q_valid); else pass_cnt++;
        sclr = 1'b0; wr_en = 1'b0; issue_en = 1'b0; rd_a_addr = 4'd2; rd_b_addr = 4'd4;
        #1;
        total_cnt++; if (busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0) $display("FAIL sclr_busy: got %b%b%b exp 000", busy_a, busy_b, stall); else pass_cnt++;
        tick();
        total_cnt++; if (q_a !== 32'd0 || q_b !== 32'd0 || q_valid !== 1'b1) $display("FAIL sclr_regs_2_4: got %h %h v=%b exp 0 0 1", q_a, q_b, q_valid); else pass_cnt++;
        rd_a_addr = 4'd1; rd_b_addr = 4'd3;
        tick();
        total_cnt++; if (q_a !== 32'd0 || q_b !== 32'd0) $display("FAIL sclr_write_dropped: got %h %h exp 0 0", q_a, q_b); else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_hazard();
        test_set_wins();
        test_soft_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_ba.md
Name: reg_file_ba

Overview:
- Parametrised general-purpose register file for the datapath, with one write port and two registered read ports (A, B).
- Port A supports base-address zeroing: when BAout is high and R0 is selected, port A reads zero, so R0 acts as a zero base in address calculation.
- A per-register busy scoreboard detects read-after-write hazards and raises a stall.
- Write-through bypass forwards same-cycle writeback data to the read ports.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 16, number of registers, 2..64.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-low reset; low clears all state.
- sclr  in  1  synchronous soft clear, active-high.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register index.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  producer issued; marks issue_addr busy.
- issue_addr  in  AW  destination register of the issued producer.
- rd_en  in  1  read request for both ports.
- rd_a_addr  in  AW  port A index.
- rd_b_addr  in  AW  port B index.
- BAout  in  1  base-address mode; zeroes port A when rd_a_addr==0.
- q_a  out  WIDTH  port A registered data.
- q_b  out  WIDTH  port B registered data.
- q_valid  out  1  one-cycle pulse: q_a/q_b updated this cycle.
- busy_a  out  1  combinational: port A operand pending.
- busy_b  out  1  combinational: port B operand pending.
- stall  out  1  combinational: rd_en & (busy_a | busy_b).

Behaviour:
- Reset (clr low, async): all registers, busy bits, q_a, q_b and q_valid go to 0 immediately.
  - Holds while clr is low; a reset mid-operation discards any in-flight read.
- Priority at a clock edge: sclr > everything else. With sclr=1:
  - registers, busy bits, q_a, q_b and q_valid become 0;
  - same-cycle wr_en, issue_en and rd_en are ignored.
- Write: wr_en=1 stores wr_data into reg[wr_addr] at the edge.
  - R0 is an ordinary writable register; BAout only affects port A reads.
- Scoreboard:
  - issue_en sets busy[issue_addr]; wr_en clears busy[wr_addr].
  - If both target the same index in one cycle, set wins, because a new producer supersedes the old one. The data write still occurs.
- busy_a = busy[rd_a_addr] & ~(wr_en & wr_addr==rd_a_addr), forced 0 when BAout & rd_a_addr==0.
- busy_b = busy[rd_b_addr] & ~(wr_en & wr_addr==rd_b_addr). BAout is ignored on port B.
- Read: one-cycle latency. At an edge with rd_en=1 and stall=0:
  - q_a <= 0 if BAout & rd_a_addr==0;
  - else q_a <= wr_data if wr_en & wr_addr==rd_a_addr (bypass);
  - else q_a <= reg[rd_a_addr];
  - q_b follows the same rule without the BAout term;
  - q_valid <= 1.
- Otherwise (rd_en=0 or stall=1): q_a and q_b hold their values and q_valid <= 0. A stalled read is not performed; the requester holds its inputs and retries.
- Out-of-range index (>= NREGS, only when NREGS is not a power of 2):
  - writes and issues are ignored;
  - reads return 0;
  - the busy term is 0.
- A same-cycle issue to a read address does not affect that cycle's busy_x. Busy_x reflects the state before the edge.
- Arithmetic: none; all data paths are WIDTH bits and pass through without modification.

Test Plan:
- Reset/hold: drive clr low mid-read, then release; then read r0..r(NREGS-1) -> all q=0, no busy, q_valid=0 during reset.
- Write/read and BAout: write R0=0xDEADBEEF, R5=0x12345678; read A=0, B=5 with BAout=0 -> next cycle q_a=0xDEADBEEF, q_b=0x12345678, q_valid=1. Repeat with BAout=1 -> q_a=0, q_b unchanged. Read A=5, B=0 with BAout=1 -> q_a=0x12345678, q_b=0xDEADBEEF.
- Bypass: wr_en with R3=0xA5A5A5A5 in the same cycle as rd_en with A=3, B=3 -> q_a=q_b=0xA5A5A5A5 one cycle later; reg[3] then reads back the same value.
- Hazard: issue R7; next cycle rd_en, A=7 -> busy_a=1, stall=1, q_valid=0, q held. Next cycle wr_en R7=0x55 while still reading -> stall=0, q_a=0x55. Following cycle busy[7]=0.
- Set-wins: same cycle issue_en=1 and wr_en=1 both to R9 with data 0x11 -> reg[9]=0x11, busy[9]=1. A read of R9 next cycle stalls.
- Soft clear: load R1..R4, issue R2, then assert sclr together with wr_en R1=0xFF and rd_en -> all registers 0, busy 0, q_a=q_b=0, q_valid=0; the write is dropped.
